// File: rtl/mem_burst_master.sv
// mem_burst_master: single-client burst master for a word-addressed memory.
// Checks the request window, waits out mem_busy, then streams write or read beats.
module mem_burst_master #(
  parameter logic [31:0] MEM_BASE     = 32'h80020000,
  parameter int unsigned MEM_WORDS    = 1048576,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] wr_data,
  output logic        wr_data_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic [1:0]  mem_acc_size,
  output logic        mem_wren,
  input  logic        mem_busy,
  output logic        mem_enable
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // One past the last valid byte address, kept 34 bits wide so it never wraps.
  localparam logic [33:0] MEM_END =
    {2'b00, MEM_BASE} + ({2'b00, 32'(MEM_WORDS)} << 2);

  // Count value in READ_WAIT on which the first read word is due next cycle.
  localparam logic [4:0] LAT_TC = 5'(READ_LATENCY - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic [4:0]  last_idx;
  logic [33:0] end_addr;
  logic        bad_req;
  logic        cmd_go;
  logic        wren;
  logic        active;

  // Burst code to index of the final beat.
  always_comb begin
    last_idx = 5'd0;
    unique case (size_q)
      2'b00: last_idx = 5'd0;
      2'b01: last_idx = 5'd3;
      2'b10: last_idx = 5'd7;
      2'b11: last_idx = 5'd15;
      default: last_idx = 5'd0;
    endcase
  end

  // Range and alignment test on the captured request.
  always_comb begin
    end_addr = {2'b00, addr_q} + {27'd0, last_idx + 5'd1, 2'b00};
    bad_req  = (addr_q[1:0] != 2'b00)
            || (addr_q < MEM_BASE)
            || (end_addr > MEM_END);
  end

  assign cmd_go = (state_q == S_WAIT) && !mem_busy;

  // Next-state, beat counting and read capture.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    write_d    = write_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wren       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          write_d = req_write;
          cnt_d   = 5'd0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = bad_req ? S_ERR : S_WAIT;
      end
      S_WAIT: begin
        if (!mem_busy) begin
          if (write_q) begin
            wren    = 1'b1;
            state_d = S_WRITE;
            if (last_idx == 5'd0) done_d = 1'b1;
            else cnt_d = 5'd1;
          end else if (READ_LATENCY < 2) begin
            state_d = S_READ;
            cnt_d   = 5'd0;
          end else begin
            state_d = S_RWAIT;
            cnt_d   = 5'd1;
          end
        end
      end
      S_WRITE: begin
        if (done_q) begin
          state_d = S_IDLE;
        end else begin
          wren = 1'b1;
          if (cnt_q == last_idx) done_d = 1'b1;
          else cnt_d = cnt_q + 5'd1;
        end
      end
      S_RWAIT: begin
        if (cnt_q >= LAT_TC) begin
          state_d = S_READ;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_READ: begin
        if (done_q) begin
          state_d = S_IDLE;
        end else begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_data_out;
          if (cnt_q == last_idx) done_d = 1'b1;
          else cnt_d = cnt_q + 5'd1;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Command stays on the bus from the command cycle through the done cycle.
  assign active = cmd_go
               || (state_q == S_WRITE)
               || (state_q == S_RWAIT)
               || (state_q == S_READ);

  assign req_ready     = reset_n && (state_q == S_IDLE);
  assign mem_enable    = reset_n;
  assign mem_wren      = wren;
  assign wr_data_ready = wren;
  assign mem_data_in   = wren ? wr_data : 32'd0;
  assign mem_addr      = active ? addr_q : 32'd0;
  assign mem_acc_size  = active ? size_q : 2'b00;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign done          = done_q;
  assign err           = (state_q == S_ERR);

endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h80020000, meaning the lowest valid byte address of main memory.
REQ-002 SHALL have parameter MEM_WORDS, default 1048576, meaning the memory depth in 32-bit words.
REQ-003 SHALL have parameter READ_LATENCY, default 2, meaning cycles from the read command cycle to the first valid mem_data_out word.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports as follows:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous reset, active low.
- req_valid  in  1  client request strobe.
- req_ready  out  1  high when a request is accepted this cycle.
- req_write  in  1  1 = burst write, 0 = burst read.
- req_addr  in  32  start byte address.
- req_size  in  2  burst length code: 00=1, 01=4, 10=8, 11=16 words.
- wr_data  in  32  write word for the current beat.
- wr_data_ready  out  1  write beat consumed this cycle.
- rd_data  out  32  read word.
- rd_valid  out  1  rd_data valid.
- done  out  1  one-cycle transaction-complete pulse.
- err  out  1  one-cycle rejected-request pulse.
- mem_addr  out  32  address to memory.
- mem_data_in  out  32  write data to memory.
- mem_data_out  in  32  read data from memory.
- mem_acc_size  out  2  burst code to memory.
- mem_wren  out  1  memory write enable.
- mem_busy  in  1  memory cannot take a command.
- mem_enable  out  1  memory enable.

Function
REQ-005 SHALL implement the states IDLE, CHECK, WAIT_BUSY, WRITE, READ_WAIT, READ and ERR.
REQ-006 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high, and addr, size and write are captured.
REQ-007 CHECK (1 cycle): SHALL go to ERR if any of the following holds; otherwise SHALL go to WAIT_BUSY.
- addr[1:0] != 0.
- addr < MEM_BASE.
- addr + 4*N > MEM_BASE + 4*MEM_WORDS, where N is the burst length.
REQ-008 ERR: SHALL pulse err for 1 cycle, issue no memory command, then return to IDLE.
REQ-009 WAIT_BUSY: SHALL hold while mem_busy=1; the first cycle with mem_busy=0 is the command cycle T.
REQ-010 SHALL hold mem_addr = captured addr and mem_acc_size = captured size from T until the transaction ends; otherwise mem_addr SHALL be 0.
REQ-011 Write: SHALL drive mem_wren=1 and mem_data_in=wr_data combinationally with wr_data_ready=1 in cycles T..T+N-1, one beat per cycle with no stalls.
REQ-012 Write: SHALL drop mem_wren in cycle T+N and pulse done in T+N.
REQ-013 Read: SHALL keep mem_wren=0 and register mem_data_out sampled in cycle T+READ_LATENCY+k as word k.
REQ-014 Read: SHALL present word k on rd_data with rd_valid=1 in cycle T+READ_LATENCY+1+k, for k = 0..N-1.
REQ-015 Read: SHALL pulse done in the same cycle as the last rd_valid.
REQ-016 SHALL count beats with a 5-bit counter; the terminal count is N-1 and the counter SHALL NOT wrap.
REQ-017 SHALL return to IDLE the cycle after done; req_ready SHALL be high that cycle.
REQ-018 SHALL ignore mem_busy once T has passed.
REQ-019 SHALL drive mem_enable=1 in every non-reset cycle.
REQ-020 SHALL ignore req_valid outside IDLE; there is no request queueing.
REQ-021 SHALL hold rd_data at its last value when rd_valid=0.

Reset
REQ-022 With reset_n=0, SHALL immediately force all outputs to 0 and the state to IDLE.
REQ-023 Reset mid-burst SHALL abort the transaction: mem_wren drops asynchronously, and no done, err or rd_valid follows.
REQ-024 SHALL assert req_ready in the first rising edge cycle after reset_n rises.

Verification
REQ-025 Single write: addr=32'h80020000, size=00, write, wr_data=32'hDEADBEEF, mem_busy=0 -> T = acceptance+2, mem_wren=1 for 1 cycle, done at T+1.
REQ-026 Burst read: size=01, READ_LATENCY=2, memory returns A0..A3 -> rd_valid at T+3..T+6 carrying A0..A3, done with A3, mem_addr constant.
REQ-027 Busy stall: mem_busy=1 for 5 cycles after CHECK -> mem_wren=0 throughout the stall, T = first busy-low cycle, then a 16-beat write with wr_data_ready high for exactly 16 cycles.
REQ-028 Errors -> err pulse, no mem_wren, next request accepted 1 cycle later:
- addr=32'h80020002.
- addr=32'h80010000.
- size=11 at the last 8 words of memory.
REQ-029 Boundary: size=11 at MEM_BASE+4*(MEM_WORDS-16) -> accepted, 16 beats, done.
REQ-030 Reset in beat 3 of an 8-word write -> all outputs 0 immediately, no done, req_ready=1 after release.
